updown_step_controller: RTL
===========================

# updown_step_controller

Control front end for the two-digit up/down BCD counter. It debounces the raw up, down and pause buttons, then issues single-cycle step_up / step_down pulses to the counter datapath. In manual mode it supports hold-to-auto-repeat; in auto mode it free-runs at a programmable rate. It replaces the raw edge detectors that currently drive the counter's increment and decrement enables.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized samples required before a debounced level changes.
- REPEAT_DELAY, 50_000_000: cycles from the initial manual pulse to the first repeat pulse.
- REPEAT_PERIOD, 10_000_000: cycles between repeat pulses while a button is held.
- AUTO_PERIOD, 10_000_000: cycles between pulses in auto mode.
- clock  in  1  system clock; every flop is rising-edge triggered.
- reset  in  1  asynchronous, active-high; clears all state.
- up  in  1  raw up button.
- down  in  1  raw down button.
- pause  in  1  raw pause button; toggles run/stop in auto mode.
- mode  in  1  switch: 0 = manual, 1 = auto. Synchronized only, not debounced.
- step_up  out  1  one-cycle increment pulse to the counter.
- step_down  out  1  one-cycle decrement pulse to the counter.
- dir  out  1  auto direction: 1 = up, 0 = down.
- running  out  1  auto mode is counting.
- state  out  3  FSM state code, for debug.

## Operation
- **Input conditioning.** Each of up, down, pause and mode passes through a 2-flop synchronizer.
- **Debounce.** up, down and pause each have a debounce counter.
  - The counter clears whenever the synchronized sample equals the debounced level.
  - The debounced level flips when the counter reaches DEBOUNCE_CYCLES.
  - Press events are rising edges of the debounced levels.
- **Pulse outputs.** step_up and step_down are registered and never high in the same cycle.
- **States.** IDLE=0, HOLD=1, REPEAT=2, LOCK=3, AUTO=4.
- **IDLE**
  - mode=1 → AUTO.
  - Exactly one of up/down presses → emit one pulse in that direction, load the timer with REPEAT_DELAY, go to HOLD.
  - Both press in the same cycle → no pulse, go to LOCK.
- **HOLD**
  - Held button releases → IDLE.
  - Other button's debounced level rises → LOCK, no pulse.
  - Timer expires → emit a pulse, load REPEAT_PERIOD, go to REPEAT.
- **REPEAT**
  - Emit a pulse and reload REPEAT_PERIOD on each expiry.
  - Release and other-button exits are the same as in HOLD.
- **LOCK**
  - No pulses.
  - Go to IDLE (or AUTO if mode=1) once both debounced levels are 0.
- **AUTO**
  - Up press sets dir=1; down press sets dir=0. A direction change does not reload the timer.
  - Pause press toggles running and reloads the timer with AUTO_PERIOD.
  - While running, emit a pulse in dir on each timer expiry, then reload AUTO_PERIOD.
- **Mode changes.** A mode change in any state has priority:
  - 0→1 leaves the manual state and enters AUTO with running=0.
  - 1→0 goes to LOCK if any button is held, otherwise to IDLE. Timer cleared, running=0.
- **Timer.** One shared down-counter, wide enough for the largest parameter. Expiry means the count reaches 1 in a counting state.
- **Reset values.** step_up=0, step_down=0, dir=1, running=0, state=IDLE. Timer and debounce counters 0, debounced levels 0.
- **Reset mid-operation.** Any in-flight pulse is dropped. A button still held after reset release produces a fresh press after full debounce.

## Timing
- **Press latency.** The pulse appears DEBOUNCE_CYCLES+3 clock edges after a clean raw rise: 2 synchronizer edges, DEBOUNCE_CYCLES debounce edges, 1 output register edge.
- **Bounce rejection.** A raw pulse or gap shorter than DEBOUNCE_CYCLES cycles causes no level change.
- **Repeat spacing.** The first repeat pulse comes exactly REPEAT_DELAY cycles after the initial pulse. Later pulses are spaced exactly REPEAT_PERIOD cycles apart.
- **Auto spacing.** The first pulse comes AUTO_PERIOD cycles after the running 0→1 toggle, then every AUTO_PERIOD cycles.
- **Release.** A release takes effect on the debounced falling edge; no pulse is issued in or after that cycle.
- **Mode latency.** Mode changes are seen 2 cycles after the raw change.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, AUTO_PERIOD=8.
- **Debounce.** up toggles high/low every 2 cycles for 20 cycles, then goes low → no step_up. up held 10 cycles → exactly one step_up, 7 edges after the rise.
- **Manual repeat.** Hold down for 50 cycles past the first pulse → step_down pulses at relative cycles 0, 20, 25, 30, 35, 40, 45 and none after release.
- **Simultaneous press.** up and down rise on the same cycle → state=3, no pulses until both are released, then state=0.
- **Auto mode.** mode=1, press pause → running=1, step_up every 8 cycles. Press down → dir=0 and subsequent pulses are step_down. Press pause → running=0, no pulses.
- **Mode switch while held.** In AUTO with up held, set mode=0 → state=3 until up is released, then 0. No spurious pulse.
- **Reset mid-repeat.** Assert reset during REPEAT → all outputs at reset values immediately. Hold up through reset release → new step_up 7 edges after release.

Source files
------------

// File: rtl/updown_step_controller.sv
// Front end for the up/down BCD counter: synchronizes and debounces the buttons,
// then issues single-cycle step pulses with manual auto-repeat or free-running auto mode.
module updown_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000,
  parameter int unsigned AUTO_PERIOD     = 10_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       pause,
  input  logic       mode,
  output logic       step_up,
  output logic       step_down,
  output logic       dir,
  output logic       running,
  output logic [2:0] state
);

  localparam int unsigned MAX_RPT   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TIMER_MAX = (MAX_RPT > AUTO_PERIOD) ? MAX_RPT : AUTO_PERIOD;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int unsigned DB_W      = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    REPEAT = 3'd2,
    LOCK   = 3'd3,
    AUTO   = 3'd4
  } state_e;

  // Bit order in the synchronizer/debounce vectors: 0=up, 1=down, 2=pause, 3=mode.
  logic [3:0]      sync1_q, sync2_q;
  logic [2:0]      level_q, level_d, level_prev_q;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];
  logic [2:0]      press;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 step_up_q, step_up_d;
  logic                 step_down_q, step_down_d;
  logic                 dir_q, dir_d;
  logic                 running_q, running_d;
  logic                 hold_up_q, hold_up_d;

  logic mode_s, up_lvl, down_lvl, held_lvl, other_press, expired;

  assign mode_s      = sync2_q[3];
  assign up_lvl      = level_q[0];
  assign down_lvl    = level_q[1];
  assign press       = level_q & ~level_prev_q;
  assign held_lvl    = hold_up_q ? up_lvl : down_lvl;
  assign other_press = hold_up_q ? press[1] : press[0];
  assign expired     = (timer_q == TIMER_W'(1));

  // The count runs only while the sample disagrees with the level; the level
  // flips on the cycle the count would reach DEBOUNCE_CYCLES.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      level_d[i]  = level_q[i];
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1))
          level_d[i] = ~level_q[i];
        else
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q      <= {mode, pause, down, up};
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    step_up_d   = 1'b0;
    step_down_d = 1'b0;
    dir_d       = dir_q;
    running_d   = running_q;
    hold_up_d   = hold_up_q;

    // Mode switch overrides whatever the current state is doing.
    if (mode_s && (state_q != AUTO)) begin
      state_d   = AUTO;
      running_d = 1'b0;
      timer_d   = '0;
    end else if (!mode_s && (state_q == AUTO)) begin
      state_d   = (up_lvl || down_lvl) ? LOCK : IDLE;
      running_d = 1'b0;
      timer_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = '0;
          if (press[0] && press[1]) begin
            state_d = LOCK;
          end else if (press[0] || press[1]) begin
            step_up_d   = press[0];
            step_down_d = press[1];
            hold_up_d   = press[0];
            timer_d     = TIMER_W'(REPEAT_DELAY);
            state_d     = HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!held_lvl) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (other_press) begin
            state_d = LOCK;
            timer_d = '0;
          end else if (expired) begin
            step_up_d   = hold_up_q;
            step_down_d = ~hold_up_q;
            timer_d     = TIMER_W'(REPEAT_PERIOD);
            state_d     = REPEAT;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        LOCK: begin
          timer_d = '0;
          if (!up_lvl && !down_lvl) state_d = IDLE;
        end
        AUTO: begin
          if (press[0])      dir_d = 1'b1;
          else if (press[1]) dir_d = 1'b0;
          if (press[2]) begin
            running_d = ~running_q;
            timer_d   = TIMER_W'(AUTO_PERIOD);
          end else if (running_q) begin
            if (expired) begin
              step_up_d   = dir_q;
              step_down_d = ~dir_q;
              timer_d     = TIMER_W'(AUTO_PERIOD);
            end else begin
              timer_d = timer_q - TIMER_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
      dir_q       <= 1'b1;
      running_q   <= 1'b0;
      hold_up_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      step_up_q   <= step_up_d;
      step_down_q <= step_down_d;
      dir_q       <= dir_d;
      running_q   <= running_d;
      hold_up_q   <= hold_up_d;
    end
  end

  assign step_up   = step_up_q;
  assign step_down = step_down_q;
  assign dir       = dir_q;
  assign running   = running_q;
  assign state     = state_q;

endmodule
